// File: rtl/grid_claim_arbiter_if.sv
// grid_claim_arbiter_if
//   Bundles the requester-side handshake and the grid RAM port of the
//   grid claim arbiter.
//
//   Handshake: a requester raises req_valid[i] together with its op/x/y/node
//   fields and holds them until it sees req_grant[i]. req_grant is a
//   single-cycle pulse in the cycle the request is accepted. After the grant
//   req_valid may drop, and the fields are no longer sampled. Exactly one
//   resp_valid[i] pulse later carries resp_ok/resp_data. If req_valid[i] is
//   still high once the arbiter is idle again, it counts as a new request.
//
//   Modports:
//     slave  - the arbiter (consumes requests and read data, drives the rest)
//     master - requesters plus grid RAM (the environment around the arbiter)
interface grid_claim_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_op;
  logic [NREQ*8-1:0]      req_x;
  logic [NREQ*8-1:0]      req_y;
  logic [NREQ*DATA_W-1:0] req_node;
  logic [NREQ-1:0]        req_grant;
  logic [NREQ-1:0]        resp_valid;
  logic                   resp_ok;
  logic [DATA_W-1:0]      resp_data;
  logic                   busy;
  logic                   mem_read;
  logic                   mem_write;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;
  logic [CNT_W-1:0]       cnt_ok;
  logic [CNT_W-1:0]       cnt_fail;

  modport slave (
    input  req_valid, req_op, req_x, req_y, req_node, mem_rdata,
    output req_grant, resp_valid, resp_ok, resp_data, busy,
           mem_read, mem_write, mem_addr, mem_wdata, cnt_ok, cnt_fail
  );

  modport master (
    output req_valid, req_op, req_x, req_y, req_node, mem_rdata,
    input  req_grant, resp_valid, resp_ok, resp_data, busy,
           mem_read, mem_write, mem_addr, mem_wdata, cnt_ok, cnt_fail
  );
endinterface

// File: rtl/grid_claim_arbiter.sv
// grid_claim_arbiter
//   Round-robin arbiter and atomic test-and-set sequencer for the shared
//   placement grid RAM. One request is served at a time as a
//   read-check-write of one cell, so no other requester can interleave.
//
//   Ports:
//     clk, reset     - clock, synchronous active-high reset
//     bus (slave)    - requester handshake, response, grid RAM port and
//                      statistics counters (see grid_claim_arbiter_if)
//     dbg_state_o    - current FSM state (state_t encoding)
//     dbg_rr_ptr_o   - current round-robin start pointer
//
//   Timing of one operation granted in IDLE at cycle t:
//     t   req_grant            (IDLE)
//     t+1 mem_read, mem_addr   (CALC)   -- or straight to RESP if out of bounds
//     t+2 capture mem_rdata    (WAIT)
//     t+3 mem_write if any     (CHECK)
//     t+4 resp_valid           (RESP)
module grid_claim_arbiter #(
  parameter int NREQ   = 4,
  parameter int GRID_N = 7,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  grid_claim_arbiter_if.slave  bus,
  output logic [2:0]           dbg_state_o,
  output logic [IDX_W-1:0]     dbg_rr_ptr_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [DATA_W-1:0] EMPTY = '1;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]        win_q, win_d;
  logic                    op_q, op_d;
  logic signed [7:0]       x_q, x_d;
  logic signed [7:0]       y_q, y_d;
  logic [DATA_W-1:0]       node_q, node_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    ok_q, ok_d;
  logic [CNT_W-1:0]        cnt_ok_q, cnt_ok_d;
  logic [CNT_W-1:0]        cnt_fail_q, cnt_fail_d;

  // Round-robin pick: first set req_valid bit starting at rr_ptr, wrapping.
  logic                    win_found;
  logic [IDX_W-1:0]        win_idx;
  int                      cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // Bounds check and linear address from the latched coordinates.
  int                      x_i, y_i, lin_i;
  logic                    in_bounds;
  logic [ADDR_W-1:0]       addr_calc;

  always_comb begin
    x_i       = int'(x_q);
    y_i       = int'(y_q);
    in_bounds = (x_i >= 0) && (x_i < GRID_N) && (y_i >= 0) && (y_i < GRID_N);
    lin_i     = x_i * GRID_N + y_i;
    addr_calc = lin_i[ADDR_W-1:0];
  end

  // Combinational strobes before reset gating.
  logic [NREQ-1:0]         grant_c;
  logic [NREQ-1:0]         resp_valid_c;
  logic                    resp_ok_c;
  logic [DATA_W-1:0]       resp_data_c;
  logic                    mem_read_c;
  logic                    mem_write_c;
  logic [ADDR_W-1:0]       mem_addr_c;
  logic [DATA_W-1:0]       mem_wdata_c;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    win_d        = win_q;
    op_d         = op_q;
    x_d          = x_q;
    y_d          = y_q;
    node_d       = node_q;
    addr_d       = addr_q;
    data_d       = data_q;
    ok_d         = ok_q;
    cnt_ok_d     = cnt_ok_q;
    cnt_fail_d   = cnt_fail_q;
    grant_c      = '0;
    resp_valid_c = '0;
    resp_ok_c    = 1'b0;
    resp_data_c  = '0;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    mem_addr_c   = '0;
    mem_wdata_c  = '0;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_c[win_idx] = 1'b1;
          win_d   = win_idx;
          op_d    = bus.req_op[win_idx];
          x_d     = bus.req_x[int'(win_idx)*8 +: 8];
          y_d     = bus.req_y[int'(win_idx)*8 +: 8];
          node_d  = bus.req_node[int'(win_idx)*DATA_W +: DATA_W];
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        if (in_bounds) begin
          mem_read_c = 1'b1;
          mem_addr_c = addr_calc;
          addr_d     = addr_calc;
          state_d    = S_WAIT;
        end else begin
          // Out of bounds: no memory access, report failure with an empty cell.
          ok_d    = 1'b0;
          data_d  = EMPTY;
          state_d = S_RESP;
        end
      end

      S_WAIT: begin
        data_d  = bus.mem_rdata;
        state_d = S_CHECK;
      end

      S_CHECK: begin
        if (!op_q) begin
          // Claim succeeds only on an empty cell.
          if (data_q == EMPTY) begin
            mem_write_c = 1'b1;
            mem_addr_c  = addr_q;
            mem_wdata_c = node_q;
            ok_d        = 1'b1;
          end else begin
            ok_d        = 1'b0;
          end
        end else begin
          // Release succeeds only when the cell holds the releasing node.
          if (data_q == node_q) begin
            mem_write_c = 1'b1;
            mem_addr_c  = addr_q;
            mem_wdata_c = EMPTY;
            ok_d        = 1'b1;
          end else begin
            ok_d        = 1'b0;
          end
        end
        state_d = S_RESP;
      end

      S_RESP: begin
        resp_valid_c[win_q] = 1'b1;
        resp_ok_c           = ok_q;
        resp_data_c         = data_q;
        if (ok_q) begin
          if (cnt_ok_q != '1) cnt_ok_d = cnt_ok_q + CNT_W'(1);
        end else begin
          if (cnt_fail_q != '1) cnt_fail_d = cnt_fail_q + CNT_W'(1);
        end
        rr_ptr_d = (int'(win_q) == NREQ - 1) ? '0 : win_q + IDX_W'(1);
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      win_q      <= '0;
      op_q       <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      node_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      ok_q       <= 1'b0;
      cnt_ok_q   <= '0;
      cnt_fail_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      win_q      <= win_d;
      op_q       <= op_d;
      x_q        <= x_d;
      y_q        <= y_d;
      node_q     <= node_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ok_q       <= ok_d;
      cnt_ok_q   <= cnt_ok_d;
      cnt_fail_q <= cnt_fail_d;
    end
  end

  // Strobes are suppressed while reset is high, so an operation interrupted
  // by reset cannot grant, write or respond in the reset cycle either.
  assign bus.req_grant  = reset ? '0   : grant_c;
  assign bus.resp_valid = reset ? '0   : resp_valid_c;
  assign bus.resp_ok    = reset ? 1'b0 : resp_ok_c;
  assign bus.resp_data  = reset ? '0   : resp_data_c;
  assign bus.mem_read   = reset ? 1'b0 : mem_read_c;
  assign bus.mem_write  = reset ? 1'b0 : mem_write_c;
  assign bus.mem_addr   = reset ? '0   : mem_addr_c;
  assign bus.mem_wdata  = reset ? '0   : mem_wdata_c;
  assign bus.busy       = !reset && (state_q != S_IDLE);
  assign bus.cnt_ok     = cnt_ok_q;
  assign bus.cnt_fail   = cnt_fail_q;

  assign dbg_state_o    = state_q;
  assign dbg_rr_ptr_o   = rr_ptr_q;

endmodule

// File: tb/tb_grid_claim_arbiter.sv
module tb_grid_claim_arbiter;
  localparam int NREQ   = 4;
  localparam int GRID_N = 7;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int NCELL  = GRID_N * GRID_N;
  localparam logic [DATA_W-1:0] EMPTY = '1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  grid_claim_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
  logic [2:0] dbg_state;
  logic [1:0] dbg_rr;

  grid_claim_arbiter #(.NREQ(NREQ), .GRID_N(GRID_N), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                       .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .dbg_state_o  (dbg_state),
    .dbg_rr_ptr_o (dbg_rr)
  );

  // ---------------- grid RAM (environment) ----------------
  logic [DATA_W-1:0] ram [0:NCELL-1] = '{default: '1};
  always @(posedge clk) begin
    if (bus.mem_read && int'(bus.mem_addr) < NCELL) bus.mem_rdata <= ram[bus.mem_addr];
    if (bus.mem_write && int'(bus.mem_addr) < NCELL) ram[bus.mem_addr] <= bus.mem_wdata;
  end

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] mgrid [0:NCELL-1] = '{default: '1};
  int exp_cnt_ok = 0;
  int exp_cnt_fail = 0;

  function automatic void model_op(input bit op, input int x, input int y,
                                   input logic [DATA_W-1:0] node,
                                   output bit ok, output logic [DATA_W-1:0] prev);
    if (x < 0 || x >= GRID_N || y < 0 || y >= GRID_N) begin
      ok = 1'b0;
      prev = EMPTY;
      return;
    end
    prev = mgrid[x * GRID_N + y];
    ok = op ? (prev == node) : (prev == EMPTY);
    if (ok) mgrid[x * GRID_N + y] = op ? EMPTY : node;
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_req(input int r, input bit op, input int x, input int y,
                         input logic [DATA_W-1:0] node);
    logic [31:0] xv, yv;
    xv = x;
    yv = y;
    bus.req_valid[r] = 1'b1;
    bus.req_op[r] = op;
    bus.req_x[r*8 +: 8] = xv[7:0];
    bus.req_y[r*8 +: 8] = yv[7:0];
    bus.req_node[r*DATA_W +: DATA_W] = node;
  endtask

  // One isolated operation with full timing checks against the expected result.
  task automatic run_op(input int r, input bit op, input int x, input int y,
                        input logic [DATA_W-1:0] node, input bit exp_ok,
                        input logic [DATA_W-1:0] exp_data, input string tag);
    int gcyc = -1, rcyc = -1, wcyc = -1, vcyc = -1, nread = 0, nwrite = 0;
    logic [NREQ-1:0] gvec = '0, vvec = '0;
    logic [ADDR_W-1:0] raddr = '0, waddr = '0;
    logic [DATA_W-1:0] wdata = '0, rdat = '0;
    logic rok = 1'b0;
    bit inb;
    int exp_addr;
    bit exp_wr;
    inb = (x >= 0) && (x < GRID_N) && (y >= 0) && (y < GRID_N);
    exp_addr = x * GRID_N + y;
    exp_wr = inb && exp_ok;
    @(negedge clk);
    set_req(r, op, x, y, node);
    for (int c = 0; c < 20 && vcyc < 0; c++) begin
      #1;
      if (bus.req_grant != '0 && gcyc < 0) begin gcyc = c; gvec = bus.req_grant; end
      if (bus.mem_read) begin nread++; rcyc = c; raddr = bus.mem_addr; end
      if (bus.mem_write) begin nwrite++; wcyc = c; waddr = bus.mem_addr; wdata = bus.mem_wdata; end
      if (bus.resp_valid != '0) begin vcyc = c; vvec = bus.resp_valid; rok = bus.resp_ok; rdat = bus.resp_data; end
      @(negedge clk);
      if (c == gcyc) bus.req_valid[r] = 1'b0;
    end
    bus.req_valid[r] = 1'b0;
    check($sformatf("%s grant", tag), gvec, 64'(1) << r);
    check($sformatf("%s grant_cycle", tag), gcyc, 0);
    if (inb) begin
      check($sformatf("%s reads", tag), nread, 1);
      check($sformatf("%s read_cycle", tag), rcyc, gcyc + 1);
      check($sformatf("%s read_addr", tag), raddr, exp_addr);
      check($sformatf("%s writes", tag), nwrite, exp_wr ? 1 : 0);
      if (exp_wr) begin
        check($sformatf("%s write_cycle", tag), wcyc, gcyc + 3);
        check($sformatf("%s write_addr", tag), waddr, exp_addr);
        check($sformatf("%s write_data", tag), wdata, op ? EMPTY : node);
      end
      check($sformatf("%s resp_cycle", tag), vcyc, gcyc + 4);
    end else begin
      check($sformatf("%s reads", tag), nread, 0);
      check($sformatf("%s writes", tag), nwrite, 0);
      check($sformatf("%s resp_cycle", tag), vcyc, gcyc + 2);
    end
    check($sformatf("%s resp_valid", tag), vvec, 64'(1) << r);
    check($sformatf("%s resp_ok", tag), rok, exp_ok);
    check($sformatf("%s resp_data", tag), rdat, exp_data);
    if (exp_ok) exp_cnt_ok++; else exp_cnt_fail++;
    #1;
    check($sformatf("%s cnt_ok", tag), bus.cnt_ok, exp_cnt_ok);
    check($sformatf("%s cnt_fail", tag), bus.cnt_fail, exp_cnt_fail);
    check($sformatf("%s busy_after", tag), bus.busy, 0);
  endtask

  // Watch n grants of held requests; each grant is matched against exp_q and
  // must be followed by its own response before the next grant.
  task automatic watch_grants(input int n, input bit drop_each, input string tag);
    int seen = 0, pending = -1, idx = 0;
    bit granted, done = 0;
    logic [1:0] e;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      granted = 0;
      if (bus.req_grant != '0) begin
        idx = 0;
        for (int i = 0; i < NREQ; i++) if (bus.req_grant[i]) idx = i;
        check($sformatf("%s grant_onehot", tag), $countones(bus.req_grant), 1);
        check($sformatf("%s grant_in_flight", tag), pending, -1);
        if (exp_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL %s extra_grant: got %0d expected none", tag, idx);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("%s grant_order", tag), idx, e);
        end
        pending = idx;
        seen++;
        granted = 1;
      end
      if (bus.resp_valid != '0) begin
        check($sformatf("%s resp_owner", tag), bus.resp_valid,
              (pending < 0) ? 64'(0) : (64'(1) << pending));
        pending = -1;
        if (seen == n) done = 1;
      end
      @(negedge clk);
      if (granted) begin
        if (drop_each) bus.req_valid[idx] = 1'b0;
        else if (seen == n) bus.req_valid = '0;
      end
    end
    check($sformatf("%s completed", tag), done, 1);
    check($sformatf("%s exp_q_empty", tag), exp_q.size(), 0);
  endtask

  task automatic wait_idle();
    #1;
    for (int c = 0; c < 20 && bus.busy; c++) begin
      @(negedge clk);
      #1;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int r;
    bit op;
    int x;
    int y;
    logic [DATA_W-1:0] node;
    bit exp_ok;
    logic [DATA_W-1:0] exp_data;
  } vec_t;

  vec_t vecs[12];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    bit mok;
    logic [DATA_W-1:0] mprev;
    int found;
    int bad;
    int r, x, y;
    bit op;
    logic [DATA_W-1:0] node;

    bus.req_valid = '0;
    bus.req_op = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.req_node = '0;

    vecs[0]  = '{0, 1'b0, 2, 3, 32'd5, 1'b1, EMPTY};
    vecs[1]  = '{1, 1'b0, 2, 3, 32'd6, 1'b0, 32'd5};
    vecs[2]  = '{2, 1'b0, 7, 0, 32'd1, 1'b0, EMPTY};
    vecs[3]  = '{3, 1'b0, -1, 0, 32'd1, 1'b0, EMPTY};
    vecs[4]  = '{0, 1'b0, 0, 7, 32'd1, 1'b0, EMPTY};
    vecs[5]  = '{1, 1'b1, 2, 3, 32'd5, 1'b1, 32'd5};
    vecs[6]  = '{2, 1'b1, 2, 3, 32'd9, 1'b0, EMPTY};
    vecs[7]  = '{3, 1'b0, 6, 6, 32'h1234, 1'b1, EMPTY};
    vecs[8]  = '{0, 1'b0, 0, 0, 32'd0, 1'b1, EMPTY};
    vecs[9]  = '{1, 1'b1, 6, 6, 32'h1234, 1'b1, 32'h1234};
    vecs[10] = '{2, 1'b0, 0, -1, 32'd2, 1'b0, EMPTY};
    vecs[11] = '{3, 1'b1, 0, 0, 32'd0, 1'b1, 32'd0};

    // Reset state, with all four requesters already asserting (out of bounds).
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 9, 0, DATA_W'(i));
    repeat (3) @(negedge clk);
    #1;
    check("reset req_grant", bus.req_grant, 0);
    check("reset resp_valid", bus.resp_valid, 0);
    check("reset resp_ok", bus.resp_ok, 0);
    check("reset resp_data", bus.resp_data, 0);
    check("reset busy", bus.busy, 0);
    check("reset mem_read", bus.mem_read, 0);
    check("reset mem_write", bus.mem_write, 0);
    check("reset mem_addr", bus.mem_addr, 0);
    check("reset mem_wdata", bus.mem_wdata, 0);
    check("reset cnt_ok", bus.cnt_ok, 0);
    check("reset cnt_fail", bus.cnt_fail, 0);
    check("reset state", dbg_state, 0);
    check("reset rr_ptr", dbg_rr, 0);

    // Contention: all held from reset release, grants rotate 0,1,2,3,0.
    @(negedge clk);
    reset = 1'b0;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    watch_grants(5, 1'b0, "contention");
    exp_cnt_fail += 5;
    wait_idle();
    check("contention cnt_fail", bus.cnt_fail, exp_cnt_fail);
    check("contention cnt_ok", bus.cnt_ok, exp_cnt_ok);

    // Directed table.
    foreach (vecs[i]) begin
      model_op(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].node, mok, mprev);
      run_op(vecs[i].r, vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].node,
             vecs[i].exp_ok, vecs[i].exp_data, $sformatf("vec%0d", i));
    end

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, NREQ - 1);
      op = 1'($urandom_range(0, 1));
      x = int'($urandom_range(0, 10)) - 2;
      y = int'($urandom_range(0, 10)) - 2;
      node = DATA_W'($urandom_range(0, 3));
      model_op(op, x, y, node, mok, mprev);
      run_op(r, op, x, y, node, mok, mprev, $sformatf("rand%0d", i));
    end

    // Reset during WAIT: no write, everything cleared, then RR restarts at 0.
    check("pre-abort cell empty", ram[3 * GRID_N + 3], mgrid[3 * GRID_N + 3]);
    @(negedge clk);
    set_req(3, 1'b0, 3, 3, 32'd7);
    found = 0;
    bad = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      #1;
      if (bus.mem_write) bad++;
      if (dbg_state == 3'd2) found = 1;
      else begin
        @(negedge clk);
        if (c >= 0) bus.req_valid[3] = 1'b0;
      end
    end
    check("abort reached WAIT", found, 1);
    reset = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    check("abort req_grant", bus.req_grant, 0);
    check("abort resp_valid", bus.resp_valid, 0);
    check("abort resp_ok", bus.resp_ok, 0);
    check("abort resp_data", bus.resp_data, 0);
    check("abort busy", bus.busy, 0);
    check("abort mem_read", bus.mem_read, 0);
    check("abort mem_write", bus.mem_write, 0);
    check("abort mem_addr", bus.mem_addr, 0);
    check("abort mem_wdata", bus.mem_wdata, 0);
    check("abort cnt_ok", bus.cnt_ok, 0);
    check("abort cnt_fail", bus.cnt_fail, 0);
    check("abort state", dbg_state, 0);
    check("abort rr_ptr", dbg_rr, 0);
    exp_cnt_ok = 0;
    exp_cnt_fail = 0;
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (bus.mem_write || bus.resp_valid != '0) bad++;
    end
    check("abort no write/resp after", bad, 0);
    check("abort cell untouched", ram[3 * GRID_N + 3], mgrid[3 * GRID_N + 3]);

    @(negedge clk);
    set_req(2, 1'b0, 9, 9, 32'd1);
    set_req(3, 1'b0, 9, 9, 32'd2);
    exp_q = '{2'd2, 2'd3};
    watch_grants(2, 1'b1, "post_reset");
    exp_cnt_fail += 2;
    wait_idle();
    check("post_reset cnt_fail", bus.cnt_fail, exp_cnt_fail);
    check("post_reset cnt_ok", bus.cnt_ok, exp_cnt_ok);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
